mem_access_sequencer: RTL and testbench

Sequences and shares the single ram512x8 port between three requesters: trap/vector fetch, data load/store, and instruction fetch. It arbitrates, latches the winning request, and drives the RAM MFA/RW/dataSize/address handshake. It waits for MFC, then returns read data and a done pulse, or an error on misalignment or timeout. It sits between the control unit and the RAM and replaces direct CU drive of the RAM control lines and trapMux.

---
 rtl/mem_access_sequencer.sv | 174 +++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Shares the single ram512x8 port between trap, data and fetch requesters:
// arbitrates, runs the MFA/MFC handshake, and reports done, error and read data.
module mem_access_sequencer #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_rw,
    input  logic [1:0]        data_size,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [2:0]        grant,
    output logic [2:0]        done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ram_mfa,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        ram_data_size,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic              ram_mfc,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_DONE} state_e;

    state_e              state_q;
    logic [2:0]          grant_q, done_q;
    logic                err_q, busy_q, mfa_q, last_data_q;
    logic [1:0]          err_code_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [CNT_W-1:0]    cnt_q;

    // Latched request and the RAM-facing copy driven from CHECK onwards.
    logic [ADDR_W-1:0]   lat_addr_q, ram_addr_q;
    logic                lat_rw_q, ram_rw_q;
    logic [1:0]          lat_size_q, ram_size_q;
    logic [DATA_W-1:0]   lat_wdata_q, ram_din_q;

    logic [2:0]          grant_d;
    logic                req_illegal;

    // Fetch only overtakes data when data won last time, so neither starves.
    always_comb begin
        grant_d = 3'b000;
        if (req[0])
            grant_d = 3'b001;
        else if (req[2] && (!req[1] || last_data_q))
            grant_d = 3'b100;
        else if (req[1])
            grant_d = 3'b010;

        req_illegal = (lat_size_q == 2'b11)
                   || (lat_size_q == 2'b01 && lat_addr_q[0])
                   || (lat_size_q == 2'b10 && lat_addr_q[1:0] != 2'b00);
    end

    // NOTE: every register here uses non-blocking assignment so all updates
    // take effect together at the edge regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mfa_q       <= 1'b0;
            last_data_q <= 1'b0;
            cnt_q       <= '0;
            lat_addr_q  <= '0;
            lat_rw_q    <= 1'b0;
            lat_size_q  <= '0;
            lat_wdata_q <= '0;
            ram_addr_q  <= '0;
            ram_rw_q    <= 1'b0;
            ram_size_q  <= '0;
            ram_din_q   <= '0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_d != 3'b000) begin
                        grant_q <= grant_d;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                        if (grant_d[1]) begin
                            lat_addr_q  <= data_addr;
                            lat_rw_q    <= data_rw;
                            lat_size_q  <= data_size;
                            lat_wdata_q <= data_wdata;
                            last_data_q <= 1'b1;
                        end else begin
                            lat_addr_q <= grant_d[0] ? trap_addr : fetch_addr;
                            lat_rw_q   <= 1'b1;
                            lat_size_q <= 2'b10;
                            if (grant_d[2])
                                last_data_q <= 1'b0;
                        end
                    end
                end
                S_CHECK: begin
                    if (req_illegal) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b01;
                        done_q     <= grant_q;
                        state_q    <= S_DONE;
                    end else begin
                        ram_addr_q <= lat_addr_q;
                        ram_rw_q   <= lat_rw_q;
                        ram_size_q <= lat_size_q;
                        if (!lat_rw_q)
                            ram_din_q <= lat_wdata_q;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mfa_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // MFC wins over the timeout when both land on the same cycle.
                    if (ram_mfc) begin
                        if (lat_rw_q)
                            rdata_q <= ram_data_out;
                        mfa_q   <= 1'b0;
                        done_q  <= grant_q;
                        state_q <= S_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        mfa_q      <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                        done_q     <= grant_q;
                        state_q    <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    grant_q    <= '0;
                    err_code_q <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant         = grant_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign rdata         = rdata_q;
    assign busy          = busy_q;
    assign ram_mfa       = mfa_q;
    assign ram_rw        = ram_rw_q;
    assign ram_addr      = ram_addr_q;
    assign ram_data_size = ram_size_q;
    assign ram_data_in   = ram_din_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: a transaction-timeline model checked every
// cycle, a RAM responder with programmable MFC delay, and directed scenarios.
module tb_mem_access_sequencer;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              Clk = 1'b0;
    logic              reset = 1'b0;
    logic [2:0]        req = '0;
    logic [ADDR_W-1:0] trap_addr = '0, fetch_addr = '0, data_addr = '0;
    logic              data_rw = 1'b1;
    logic [1:0]        data_size = 2'b10;
    logic [DATA_W-1:0] data_wdata = '0;
    logic [2:0]        grant, done;
    logic              err, busy, ram_mfa, ram_rw;
    logic [1:0]        err_code, ram_data_size;
    logic [DATA_W-1:0] rdata, ram_data_in;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_mfc = 1'b0;
    logic [DATA_W-1:0] ram_data_out = '0;

    mem_access_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .reset(reset), .req(req),
        .trap_addr(trap_addr), .fetch_addr(fetch_addr), .data_addr(data_addr),
        .data_rw(data_rw), .data_size(data_size), .data_wdata(data_wdata),
        .grant(grant), .done(done), .err(err), .err_code(err_code),
        .rdata(rdata), .busy(busy), .ram_mfa(ram_mfa), .ram_rw(ram_rw),
        .ram_addr(ram_addr), .ram_data_size(ram_data_size),
        .ram_data_in(ram_data_in), .ram_mfc(ram_mfc), .ram_data_out(ram_data_out)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM responder: MFC k cycles after mfa rises ----------------
    int mfc_k = 0;          // 0 = never answer
    bit force_mfc = 0;
    bit mfa_seen = 0;
    int mfa_cnt = 0;
    int mfa_high_cycles = 0;

    initial forever begin
        @(negedge Clk);
        if (ram_mfa) begin
            mfa_cnt  = mfa_seen ? mfa_cnt + 1 : 0;
            mfa_seen = 1;
            ram_mfc  = (mfc_k != 0) && (mfa_cnt == mfc_k);
            mfa_high_cycles++;
        end else begin
            mfa_seen = 0;
            ram_mfc  = force_mfc;
        end
    end

    // ---------------- Transaction-timeline model ----------------
    // Each transaction is described by its grant edge t0: RAM lines settle at
    // t0+1, mfa rises at t0+2, completion at first sampled MFC or at t0+2+TIMEOUT.
    int  cyc = 0, t0 = 0, t_end = -1, m_owner = 0;
    bit  m_active = 0, m_last_data = 0, m_illegal = 0, m_rw = 0;
    logic [ADDR_W-1:0] m_addr;
    logic [1:0]        m_size;
    logic [DATA_W-1:0] m_wdata;
    logic [2:0]        e_grant = '0, e_done = '0;
    logic              e_err = 0, e_busy = 0, e_mfa = 0, e_rw = 0;
    logic [1:0]        e_code = '0, e_size = '0;
    logic [DATA_W-1:0] e_rdata = '0, e_din = '0;
    logic [ADDR_W-1:0] e_addr = '0;

    function automatic int pick(input logic [2:0] r, input bit last_data);
        if (r[0]) return 0;
        if (r[1] && r[2]) return last_data ? 2 : 1;
        return r[1] ? 1 : 2;
    endfunction

    task automatic model_finish(input logic [1:0] code);
        t_end  = cyc;
        e_mfa  = 0;
        e_done = 3'(1 << m_owner);
        e_err  = (code != 2'b00);
        e_code = code;
    endtask

    task automatic model_step();
        int rel;
        cyc++;
        e_done = '0;
        e_err  = 0;
        if (!reset) begin
            m_active = 0; m_last_data = 0;
            e_grant = '0; e_code = '0; e_rdata = '0; e_busy = 0; e_mfa = 0;
            e_rw = 0; e_addr = '0; e_size = '0; e_din = '0;
        end else if (!m_active) begin
            if (req != 3'b000) begin
                m_owner = pick(req, m_last_data);
                if (m_owner == 1) begin
                    m_last_data = 1;
                    m_addr = data_addr; m_rw = data_rw; m_size = data_size; m_wdata = data_wdata;
                end else begin
                    if (m_owner == 2) m_last_data = 0;
                    m_addr = (m_owner == 0) ? trap_addr : fetch_addr;
                    m_rw = 1; m_size = 2'b10;
                end
                m_illegal = (m_size == 2'b11) || (m_size == 2'b01 && m_addr % 2 != 0)
                         || (m_size == 2'b10 && m_addr % 4 != 0);
                t0 = cyc; t_end = -1; m_active = 1;
                e_grant = 3'(1 << m_owner);
                e_busy = 1;
            end
        end else begin
            rel = cyc - t0;
            if (t_end >= 0) begin
                e_grant = '0; e_code = '0; e_busy = 0; m_active = 0;
            end else if (m_illegal) begin
                model_finish(2'b01);
            end else if (rel == 1) begin
                e_addr = m_addr; e_rw = m_rw; e_size = m_size;
                if (!m_rw) e_din = m_wdata;
            end else if (rel == 2) begin
                e_mfa = 1;
            end else if (ram_mfc) begin
                if (m_rw) e_rdata = ram_data_out;
                model_finish(2'b00);
            end else if (rel == 2 + TIMEOUT) begin
                model_finish(2'b10);
            end
        end
    endtask

    initial forever begin
        @(posedge Clk);
        model_step();
    end

    bit cmp_en = 0;
    always @(negedge Clk) begin
        if (cmp_en) begin
            check("grant", grant, e_grant);
            check("done", done, e_done);
            check("err", err, e_err);
            check("err_code", err_code, e_code);
            check("rdata", rdata, e_rdata);
            check("busy", busy, e_busy);
            check("ram_mfa", ram_mfa, e_mfa);
            check("ram_rw", ram_rw, e_rw);
            check("ram_addr", ram_addr, e_addr);
            check("ram_data_size", ram_data_size, e_size);
            check("ram_data_in", ram_data_in, e_din);
        end
    end

    // ---------------- Stimulus ----------------
    task automatic wait_done(output logic [2:0] d, output logic [2:0] g, output int lat);
        bit seen = 0;
        d = '0; g = '0; lat = -1;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge Clk);
            if (done != 3'b000) begin
                seen = 1; d = done; g = grant; lat = i - 1;
                req = req & ~done;
            end
        end
        check("done_seen", seen, 1);
    endtask

    logic [2:0] d, g;
    int lat;
    logic [2:0] exp_order [3];

    initial begin
        repeat (2) @(negedge Clk);
        cmp_en = 1;
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_mfa", ram_mfa, 0);
        check("rst_rdata", rdata, 0);
        reset = 1;
        @(negedge Clk);

        // Fetch only, MFC two cycles after mfa
        fetch_addr = 9'h010; ram_data_out = 32'hDEADBEEF; mfc_k = 2;
        req = 3'b100;
        wait_done(d, g, lat);
        check("fetch_done", d, 3'b100);
        check("fetch_latency", lat, 5);
        check("fetch_err", err, 0);
        check("fetch_addr", ram_addr, 9'h010);
        check("fetch_rw", ram_rw, 1);
        check("fetch_size", ram_data_size, 2'b10);
        check("fetch_rdata", rdata, 32'hDEADBEEF);

        // All three at once: trap, data, fetch
        trap_addr = 9'h004; data_addr = 9'h008; data_rw = 1; data_size = 2'b10;
        fetch_addr = 9'h00C; ram_data_out = 32'h11112222; mfc_k = 1;
        exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100;
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wait_done(d, g, lat);
            check("prio_grant", g, exp_order[i]);
            check("prio_done_onehot", d, exp_order[i]);
            @(negedge Clk);
            check("prio_done_pulse", done, 0);
        end

        // Data and fetch both held: must alternate
        data_addr = 9'h014; ram_data_out = 32'h33334444;
        exp_order[0] = 3'b010; exp_order[1] = 3'b100; exp_order[2] = 3'b010;
        req = 3'b110;
        for (int i = 0; i < 3; i++) begin
            wait_done(d, g, lat);
            check("alt_grant", g, exp_order[i]);
            req = (i < 2) ? 3'b110 : 3'b000;
        end

        // Misaligned halfword write and illegal size: no RAM access
        data_rw = 0; data_size = 2'b01; data_addr = 9'h003; data_wdata = 32'h00000055;
        @(negedge Clk);
        mfa_high_cycles = 0;
        req = 3'b010;
        wait_done(d, g, lat);
        check("mis_done", d, 3'b010);
        check("mis_latency", lat, 1);
        check("mis_err", err, 1);
        check("mis_code", err_code, 2'b01);
        check("mis_no_mfa", mfa_high_cycles, 0);
        check("mis_rdata", rdata, 32'h33334444);
        @(negedge Clk);
        data_rw = 1; data_size = 2'b11; data_addr = 9'h000;
        req = 3'b010;
        wait_done(d, g, lat);
        check("size11_code", err_code, 2'b01);
        check("size11_no_mfa", mfa_high_cycles, 0);

        // Legal word write
        @(negedge Clk);
        data_rw = 0; data_size = 2'b10; data_addr = 9'h020; data_wdata = 32'hCAFEF00D;
        req = 3'b010;
        wait_done(d, g, lat);
        check("wr_latency", lat, 4);
        check("wr_err", err, 0);
        check("wr_din", ram_data_in, 32'hCAFEF00D);
        check("wr_rw", ram_rw, 0);
        check("wr_rdata", rdata, 32'h33334444);

        // Timeout: RAM never answers
        @(negedge Clk);
        data_rw = 1; data_addr = 9'h024; mfc_k = 0;
        mfa_high_cycles = 0;
        req = 3'b010;
        wait_done(d, g, lat);
        check("to_done", d, 3'b010);
        check("to_latency", lat, 2 + TIMEOUT);
        check("to_err", err, 1);
        check("to_code", err_code, 2'b10);
        check("to_mfa_cycles", mfa_high_cycles, 16);
        @(negedge Clk);
        check("to_busy_low", busy, 0);
        check("to_rdata", rdata, 32'h33334444);

        // Reset in WAIT, then a stray MFC
        data_addr = 9'h028;
        req = 3'b010;
        for (int i = 0; i < 10 && !ram_mfa; i++) @(negedge Clk);
        check("rw_mfa_rose", ram_mfa, 1);
        repeat (3) @(negedge Clk);
        req = 3'b000;
        reset = 0;
        @(negedge Clk);
        check("rw_mfa", ram_mfa, 0);
        check("rw_grant", grant, 0);
        check("rw_busy", busy, 0);
        check("rw_done", done, 0);
        reset = 1;
        force_mfc = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("stray_mfc_done", done, 0);
            check("stray_mfc_busy", busy, 0);
        end
        force_mfc = 0;
        repeat (2) @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
